mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port RAM arbiter and access sequencer between the CPU's instruction-fetch path and its load/store data path. It accepts level-held requests from both ports, grants one, and drives the shared RAM command/address/data lines for a fixed access latency. It captures read data and returns a one-cycle acknowledge to the winning port. It sits between the control/fetch logic and the RAM, and uses the shared RAM command codes `RAM_NONE`, `RAM_READ` and `RAM_WRITE`.

## Interface
- `RAM_LAT`, default 1: RAM access cycles per transaction; legal values are ≥1.
- `W`, default 32: data and address width.

Ports:
- `i_clk`  in  1  clock; all logic on the rising edge.
- `i_rst`  in  1  reset, synchronous and active-high.
- `i_f_req`  in  1  fetch request, held until ack.
- `i_f_addr`  in  W  fetch address.
- `o_f_ack`  out  1  fetch done, one-cycle pulse.
- `o_f_rdata`  out  W  fetched word, registered.
- `i_d_req`  in  1  data request, held until ack.
- `i_d_op`  in  2  `RAM_READ` or `RAM_WRITE`.
- `i_d_addr`  in  W  data address.
- `i_d_wdata`  in  W  store data.
- `o_d_ack`  out  1  data done, one-cycle pulse.
- `o_d_rdata`  out  W  loaded word, registered.
- `o_ram_do`  out  2  RAM command.
- `o_ram_addr`  out  W  RAM address.
- `o_ram_wdata`  out  W  RAM write data.
- `i_ram_rdata`  in  W  RAM read data, valid on the last access cycle.
- `o_busy`  out  1  high when the state is not IDLE.

## Operation
- FSM states:
  - IDLE → ACCESS when a valid request is present.
  - ACCESS holds for `RAM_LAT` cycles, then → ACK.
  - ACK → IDLE unconditionally.
- Valid request:
  - `i_f_req` is always a valid request.
  - `i_d_req` is valid only when `i_d_op` is `RAM_READ` or `RAM_WRITE`.
  - `i_d_req` with `RAM_NONE` is ignored: no grant, no ack.
- On the IDLE→ACCESS edge:
  - Latch the grant (F or D), the address, the op (fetch is always `RAM_READ`) and the write data.
  - Later changes on the request inputs are ignored until ACK.
- During ACCESS:
  - `o_ram_do`, `o_ram_addr` and `o_ram_wdata` are driven from the latched values.
  - A latency counter counts from 0 to `RAM_LAT`-1.
  - On the last cycle, a read registers `i_ram_rdata` into the granted port's rdata register.
- In ACK:
  - The granted port's ack is high for exactly one cycle.
  - `o_ram_do` = `RAM_NONE`.
  - Requests are not sampled.
  - A requester that still holds req in the following IDLE cycle is treated as issuing a new transaction.
- Outside ACCESS, `o_ram_do` = `RAM_NONE` and `o_ram_addr`/`o_ram_wdata` hold their last latched values.
- rdata registers:
  - Each holds its value until that port's next read completes.
  - A write ack leaves `o_d_rdata` unchanged.
- Arbitration when both ports are valid in IDLE: D wins (fixed priority; see Configuration for fair mode). A single valid request is granted immediately.
- Reset values, applied on any cycle with `i_rst` high:
  - state = IDLE, counter = 0.
  - `o_ram_do` = `RAM_NONE`, `o_ram_addr`, `o_ram_wdata` and both rdata = 0.
  - Both acks = 0, `o_busy` = 0, last-grant = F.
- Reset mid-transaction aborts it: no ack is issued and no rdata is updated.

## Timing
- Request sampled in IDLE at cycle 0:
  - ACCESS occupies cycles 1..`RAM_LAT`.
  - Ack at cycle `RAM_LAT`+1.
  - rdata is valid in the ack cycle.
- Throughput is one transaction per `RAM_LAT`+2 cycles per back-to-back pair.
- `o_busy` is high from cycle 1 through the ack cycle.
- All outputs are registered; no combinational path runs from request inputs to RAM outputs.

## Configuration
- Macro `MEM_ARB_FAIR_EN` selects the tie-break when both ports are valid in IDLE.
- Defined:
  - Round-robin tie-break: grant the port not granted last.
  - A 1-bit last-grant register updates on each grant.
  - A single valid requester still wins immediately.
- Undefined:
  - Fixed D-over-F priority.
  - A continuously requesting D port starves F.
  - No last-grant register.

## Structure
- Shared package/defines hold:
  - `RAM_NONE`/`RAM_READ`/`RAM_WRITE` codes (existing).
  - FSM state encoding (IDLE, ACCESS, ACK).
  - Grant encoding (F, D).
- One combinational sub-module, `mem_arb_pick`:
  - Inputs: the two valid bits and last-grant.
  - Outputs: grant-valid and grant-select.
  - Fair/fixed policy is selected by `MEM_ARB_FAIR_EN` inside it.
- The FSM, latency counter, latches and rdata registers stay in `mem_arbiter`.

## Test plan
- Fetch alone, `RAM_LAT`=1, addr 0x40, RAM returns 0xDEADBEEF:
  - `o_ram_do`=`RAM_READ` and addr 0x40 in cycle 1.
  - `o_f_ack` pulses in cycle 2 with `o_f_rdata`=0xDEADBEEF.
  - `o_d_ack` stays 0.
- Data write, `RAM_LAT`=3, addr 0x100, wdata 0x12345678:
  - `RAM_WRITE` held for cycles 1–3.
  - `o_d_ack` in cycle 4.
  - `o_d_rdata` unchanged.
- Both ports request, both held for 4 transactions:
  - Fixed mode: grants are D,D,D,D and F never acked.
  - `MEM_ARB_FAIR_EN` mode: grants are D,F,D,F.
- `i_d_req`=1 with `i_d_op`=`RAM_NONE` and no fetch: state stays IDLE, `o_busy`=0, no ack for 10 cycles.
- `i_rst` asserted in the second ACCESS cycle of a `RAM_LAT`=3 read:
  - Next cycle `o_ram_do`=`RAM_NONE`, `o_busy`=0 and rdata=0.
  - No ack ever issued for the aborted read.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the RAM arbiter slice: the RAM command codes,
// the arbiter FSM state encoding and the grant encoding.
package mem_arbiter_pkg;

  // RAM command codes shared with the control/fetch logic.
  localparam logic [1:0] RAM_NONE  = 2'd0;
  localparam logic [1:0] RAM_READ  = 2'd1;
  localparam logic [1:0] RAM_WRITE = 2'd2;

  // Arbiter FSM states.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;

  // Grant encoding: which port owns the current transaction.
  localparam logic GNT_F = 1'b0;
  localparam logic GNT_D = 1'b1;

  // A data-port request only counts when it carries a real RAM command.
  function automatic logic is_ram_op(input logic [1:0] op);
    return (op == RAM_READ) || (op == RAM_WRITE);
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational grant picker for mem_arbiter.
// Macro MEM_ARB_FAIR_EN: defined selects a round-robin tie-break using the
// last grant; undefined gives fixed D-over-F priority.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic f_valid,
  input  logic d_valid,
  input  logic last_gnt,
  output logic gnt_valid,
  output logic gnt_sel
);

  assign gnt_valid = f_valid | d_valid;

`ifndef MEM_ARB_FAIR_EN
  // Fixed priority ignores history; the input exists only for port symmetry.
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
`endif

  // Choose the winning port; a lone requester always wins.
  always_comb begin
    // NOTE: assign every always_comb output a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    gnt_sel = GNT_F;
`ifdef MEM_ARB_FAIR_EN
    if (f_valid && d_valid) begin
      gnt_sel = (last_gnt == GNT_D) ? GNT_F : GNT_D;
    end else if (d_valid) begin
      gnt_sel = GNT_D;
    end
`else
    if (d_valid) begin
      gnt_sel = GNT_D;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter/sequencer between the instruction-fetch port (F)
// and the load/store data port (D). Grants one level-held request, drives
// the RAM for RAM_LAT cycles, captures read data and pulses the winner's ack.
// Macro MEM_ARB_FAIR_EN: round-robin tie-break (default: D has priority).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RAM_LAT = 1,
  parameter int W       = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_f_req,
  input  logic [W-1:0] i_f_addr,
  output logic         o_f_ack,
  output logic [W-1:0] o_f_rdata,
  input  logic         i_d_req,
  input  logic [1:0]   i_d_op,
  input  logic [W-1:0] i_d_addr,
  input  logic [W-1:0] i_d_wdata,
  output logic         o_d_ack,
  output logic [W-1:0] o_d_rdata,
  output logic [1:0]   o_ram_do,
  output logic [W-1:0] o_ram_addr,
  output logic [W-1:0] o_ram_wdata,
  input  logic [W-1:0] i_ram_rdata,
  output logic         o_busy
);

  localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RAM_LAT - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          gnt;
  logic          last_gnt;
  logic          f_valid;
  logic          d_valid;
  logic          gnt_valid;
  logic          gnt_sel;

  // A D request without a real command is invisible to arbitration.
  assign f_valid = i_f_req;
  assign d_valid = i_d_req && is_ram_op(i_d_op);

  mem_arb_pick u_pick (
    .f_valid   (f_valid),
    .d_valid   (d_valid),
    .last_gnt  (last_gnt),
    .gnt_valid (gnt_valid),
    .gnt_sel   (gnt_sel)
  );

`ifdef MEM_ARB_FAIR_EN
  // Remember the most recent winner for the round-robin tie-break.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_gnt <= GNT_F;
    end else if (state == ST_IDLE && gnt_valid) begin
      last_gnt <= gnt_sel;
    end
  end
`else
  assign last_gnt = GNT_F;
`endif

  assign o_busy = (state != ST_IDLE);

  // FSM, latency counter, command latches, acks and read-data capture.
  // o_ram_do doubles as the latched op: it is only non-NONE during ACCESS.
  always_ff @(posedge i_clk) begin
    // NOTE: state elements use non-blocking assignments so every register
    // in the block sees the pre-edge values, independent of statement order.
    if (i_rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      gnt         <= GNT_F;
      o_ram_do    <= RAM_NONE;
      o_ram_addr  <= '0;
      o_ram_wdata <= '0;
      o_f_rdata   <= '0;
      o_d_rdata   <= '0;
      o_f_ack     <= 1'b0;
      o_d_ack     <= 1'b0;
    end else begin
      o_f_ack <= 1'b0;
      o_d_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            state       <= ST_ACCESS;
            cnt         <= '0;
            gnt         <= gnt_sel;
            o_ram_do    <= (gnt_sel == GNT_D) ? i_d_op : RAM_READ;
            o_ram_addr  <= (gnt_sel == GNT_D) ? i_d_addr : i_f_addr;
            o_ram_wdata <= i_d_wdata;
          end
        end
        ST_ACCESS: begin
          if (cnt == CNT_LAST) begin
            state    <= ST_ACK;
            cnt      <= '0;
            o_ram_do <= RAM_NONE;
            if (gnt == GNT_D) begin
              o_d_ack <= 1'b1;
              if (o_ram_do == RAM_READ) begin
                o_d_rdata <= i_ram_rdata;
              end
            end else begin
              o_f_ack   <= 1'b1;
              o_f_rdata <= i_ram_rdata;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state    <= ST_IDLE;
          o_ram_do <= RAM_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with RAM_LAT=1 and one with
// RAM_LAT=3 share the same request stimulus; each sequence checks one of them.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        f_req;
  logic [31:0] f_addr;
  logic        d_req;
  logic [1:0]  d_op;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] ram_rdata;

  logic        f_ack1, d_ack1, busy1;
  logic [31:0] f_rdata1, d_rdata1, ram_addr1, ram_wdata1;
  logic [1:0]  ram_do1;
  logic        f_ack3, d_ack3, busy3;
  logic [31:0] f_rdata3, d_rdata3, ram_addr3, ram_wdata3;
  logic [1:0]  ram_do3;

  int n_vec  = 0;
  int n_miss = 0;

  mem_arbiter #(.RAM_LAT(1), .W(32)) u_dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_f_req(f_req), .i_f_addr(f_addr), .o_f_ack(f_ack1), .o_f_rdata(f_rdata1),
    .i_d_req(d_req), .i_d_op(d_op), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_ack(d_ack1), .o_d_rdata(d_rdata1),
    .o_ram_do(ram_do1), .o_ram_addr(ram_addr1), .o_ram_wdata(ram_wdata1),
    .i_ram_rdata(ram_rdata), .o_busy(busy1)
  );

  mem_arbiter #(.RAM_LAT(3), .W(32)) u_dut3 (
    .i_clk(clk), .i_rst(rst),
    .i_f_req(f_req), .i_f_addr(f_addr), .o_f_ack(f_ack3), .o_f_rdata(f_rdata3),
    .i_d_req(d_req), .i_d_op(d_op), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_ack(d_ack3), .o_d_rdata(d_rdata3),
    .o_ram_do(ram_do3), .o_ram_addr(ram_addr3), .o_ram_wdata(ram_wdata3),
    .i_ram_rdata(ram_rdata), .o_busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        f_req;
    logic [31:0] f_addr;
    logic        d_req;
    logic [1:0]  d_op;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] ram_rdata;
    logic [1:0]  x_do;
    logic [31:0] x_addr;
    logic        x_busy;
    logic        x_f_ack;
    logic        x_d_ack;
    logic [31:0] x_f_rdata;
    logic [31:0] x_d_rdata;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(
    input logic fr, input logic [31:0] fa, input logic dr, input logic [1:0] op,
    input logic [31:0] da, input logic [31:0] dw, input logic [31:0] rr,
    input logic [1:0] xdo, input logic [31:0] xa, input logic xb,
    input logic xfa, input logic xda, input logic [31:0] xfr, input logic [31:0] xdr);
    vec_t v;
    v.f_req = fr; v.f_addr = fa; v.d_req = dr; v.d_op = op;
    v.d_addr = da; v.d_wdata = dw; v.ram_rdata = rr;
    v.x_do = xdo; v.x_addr = xa; v.x_busy = xb;
    v.x_f_ack = xfa; v.x_d_ack = xda; v.x_f_rdata = xfr; v.x_d_rdata = xdr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_op = RAM_NONE;
    d_addr = '0; d_wdata = '0; ram_rdata = '0;
  endtask

  task automatic reset_duts();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        got;
    logic        sel;
    logic        exp_sel;
    int          cyc;

    // Cycle-by-cycle table for the RAM_LAT=1 instance.
    tbl[0]  = mk(1, 32'h40, 0, RAM_NONE,  0,     0,            32'hDEADBEEF, RAM_READ,  32'h40, 1, 0, 0, 32'h0,        32'h0);
    tbl[1]  = mk(1, 32'h40, 0, RAM_NONE,  0,     0,            32'hDEADBEEF, RAM_NONE,  32'h40, 1, 1, 0, 32'hDEADBEEF, 32'h0);
    tbl[2]  = mk(0, 0,      0, RAM_NONE,  0,     0,            0,            RAM_NONE,  32'h40, 0, 0, 0, 32'hDEADBEEF, 32'h0);
    tbl[3]  = mk(0, 0,      1, RAM_READ,  32'h80, 0,           32'hCAFEF00D, RAM_READ,  32'h80, 1, 0, 0, 32'hDEADBEEF, 32'h0);
    tbl[4]  = mk(0, 0,      1, RAM_READ,  32'h80, 0,           32'hCAFEF00D, RAM_NONE,  32'h80, 1, 0, 1, 32'hDEADBEEF, 32'hCAFEF00D);
    tbl[5]  = mk(1, 32'h44, 0, RAM_NONE,  0,     0,            32'h11112222, RAM_NONE,  32'h80, 0, 0, 0, 32'hDEADBEEF, 32'hCAFEF00D);
    tbl[6]  = mk(1, 32'h44, 0, RAM_NONE,  0,     0,            32'h11112222, RAM_READ,  32'h44, 1, 0, 0, 32'hDEADBEEF, 32'hCAFEF00D);
    tbl[7]  = mk(1, 32'h44, 0, RAM_NONE,  0,     0,            32'h11112222, RAM_NONE,  32'h44, 1, 1, 0, 32'h11112222, 32'hCAFEF00D);
    tbl[8]  = mk(0, 0,      1, RAM_WRITE, 32'h88, 32'hA5A5A5A5, 32'hFFFFFFFF, RAM_NONE, 32'h44, 0, 0, 0, 32'h11112222, 32'hCAFEF00D);
    tbl[9]  = mk(0, 0,      1, RAM_WRITE, 32'h88, 32'hA5A5A5A5, 32'hFFFFFFFF, RAM_WRITE, 32'h88, 1, 0, 0, 32'h11112222, 32'hCAFEF00D);
    tbl[10] = mk(0, 0,      0, RAM_NONE,  0,     0,            32'hFFFFFFFF, RAM_NONE,  32'h88, 1, 0, 1, 32'h11112222, 32'hCAFEF00D);
    tbl[11] = mk(0, 0,      0, RAM_NONE,  0,     0,            0,            RAM_NONE,  32'h88, 0, 0, 0, 32'h11112222, 32'hCAFEF00D);

    rst = 1'b0;
    reset_duts();

    // Reset state of both instances.
    check("rst ram_do1",    ram_do1,    RAM_NONE);
    check("rst ram_addr1",  ram_addr1,  0);
    check("rst ram_wdata1", ram_wdata1, 0);
    check("rst busy1",      busy1,      0);
    check("rst acks1",      {f_ack1, d_ack1}, 0);
    check("rst rdata1",     f_rdata1 | d_rdata1, 0);
    check("rst ram_do3",    ram_do3,    RAM_NONE);
    check("rst busy3",      busy3,      0);
    check("rst rdata3",     f_rdata3 | d_rdata3, 0);

    // Table: fetch, data read, ACK-cycle non-sampling, write keeps d_rdata.
    for (int i = 0; i < 12; i++) begin
      f_req = tbl[i].f_req; f_addr = tbl[i].f_addr;
      d_req = tbl[i].d_req; d_op = tbl[i].d_op;
      d_addr = tbl[i].d_addr; d_wdata = tbl[i].d_wdata;
      ram_rdata = tbl[i].ram_rdata;
      tick();
      check($sformatf("row%0d ram_do", i),  ram_do1,  tbl[i].x_do);
      check($sformatf("row%0d ram_addr", i), ram_addr1, tbl[i].x_addr);
      check($sformatf("row%0d busy", i),    busy1,    tbl[i].x_busy);
      check($sformatf("row%0d f_ack", i),   f_ack1,   tbl[i].x_f_ack);
      check($sformatf("row%0d d_ack", i),   d_ack1,   tbl[i].x_d_ack);
      check($sformatf("row%0d f_rdata", i), f_rdata1, tbl[i].x_f_rdata);
      check($sformatf("row%0d d_rdata", i), d_rdata1, tbl[i].x_d_rdata);
    end

    // Both ports hold requests for four transactions (RAM_LAT=1).
    reset_duts();
    f_req = 1'b1; f_addr = 32'h200;
    d_req = 1'b1; d_op = RAM_READ; d_addr = 32'h300;
    ram_rdata = 32'h5A5A0000;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      sel = GNT_F;
      cyc = 0;
      while (!got && cyc < 8) begin
        tick();
        cyc++;
        if (f_ack1 || d_ack1) begin
          got = 1'b1;
          sel = d_ack1 ? GNT_D : GNT_F;
          check($sformatf("pair%0d one ack", k), {31'b0, f_ack1 & d_ack1}, 0);
        end
      end
`ifdef MEM_ARB_FAIR_EN
      exp_sel = (k % 2 == 0) ? GNT_D : GNT_F;
`else
      exp_sel = GNT_D;
`endif
      check($sformatf("pair%0d ack seen", k), {31'b0, got}, 1);
      check($sformatf("pair%0d grant", k), {31'b0, sel}, {31'b0, exp_sel});
    end
    idle_inputs();
    tick();
    tick();

    // D request with RAM_NONE and no fetch: nothing happens for 10 cycles.
    reset_duts();
    d_req = 1'b1; d_op = RAM_NONE; d_addr = 32'h55;
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("none c%0d busy", c), {30'b0, busy1, busy3}, 0);
      check($sformatf("none c%0d acks", c), {28'b0, f_ack1, d_ack1, f_ack3, d_ack3}, 0);
      check($sformatf("none c%0d ram_do", c), ram_do3, RAM_NONE);
    end
    idle_inputs();

    // RAM_LAT=3: a data read to give d_rdata a known value.
    reset_duts();
    d_req = 1'b1; d_op = RAM_READ; d_addr = 32'h10; ram_rdata = 32'h0BADF00D;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("rd3 c%0d ram_do", c), ram_do3, RAM_READ);
      check($sformatf("rd3 c%0d d_ack", c), d_ack3, 0);
    end
    tick();
    check("rd3 ack", d_ack3, 1);
    check("rd3 d_rdata", d_rdata3, 32'h0BADF00D);
    d_req = 1'b0; d_op = RAM_NONE;
    tick();
    check("rd3 idle busy", busy3, 0);

    // RAM_LAT=3 write: command held cycles 1..3, ack in cycle 4.
    d_req = 1'b1; d_op = RAM_WRITE; d_addr = 32'h100; d_wdata = 32'h12345678;
    ram_rdata = 32'hFFFFFFFF;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("wr3 c%0d ram_do", c), ram_do3, RAM_WRITE);
      check($sformatf("wr3 c%0d ram_addr", c), ram_addr3, 32'h100);
      check($sformatf("wr3 c%0d ram_wdata", c), ram_wdata3, 32'h12345678);
      check($sformatf("wr3 c%0d busy", c), busy3, 1);
      check($sformatf("wr3 c%0d d_ack", c), d_ack3, 0);
    end
    tick();
    check("wr3 ack", d_ack3, 1);
    check("wr3 ack f_ack", f_ack3, 0);
    check("wr3 ack ram_do", ram_do3, RAM_NONE);
    check("wr3 d_rdata kept", d_rdata3, 32'h0BADF00D);
    d_req = 1'b0; d_op = RAM_NONE;
    tick();
    check("wr3 idle ack", d_ack3, 0);
    check("wr3 idle ram_addr", ram_addr3, 32'h100);

    // RAM_LAT=3 read aborted by reset in its second ACCESS cycle.
    d_req = 1'b1; d_op = RAM_READ; d_addr = 32'h20; ram_rdata = 32'h77777777;
    tick();
    check("abort c1 ram_do", ram_do3, RAM_READ);
    tick();
    check("abort c2 busy", busy3, 1);
    rst = 1'b1;
    d_req = 1'b0; d_op = RAM_NONE;
    tick();
    rst = 1'b0;
    check("abort ram_do", ram_do3, RAM_NONE);
    check("abort busy", busy3, 0);
    check("abort d_rdata", d_rdata3, 0);
    check("abort ram_addr", ram_addr3, 0);
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("abort post c%0d acks", c), {30'b0, f_ack3, d_ack3}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
